fd_queue: RTL and testbench

Parametrised fetch/decode boundary buffer that replaces the single-entry F/D pipeline register with a DEPTH-entry instruction FIFO. It sits between the fetch stage and decode, decoupling fetch stalls from decode stalls. It keeps the existing F/D duties: the NOP bubble on flush, EPC-preserving bubble PC on eret/likely, PC+8 generation and delay-slot marking. It adds valid/ready handshakes on both sides and an optional same-cycle bypass.

---
 rtl/fd_queue_if.sv | 40 ++++
 rtl/fd_queue.sv | 102 ++++++++++
 tb/tb_fd_queue.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fd_queue_if.sv
// Fetch/decode boundary bundle: fetch-side handshake, decode-side head view, flush control.
interface fd_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  in_ins;
  logic [XLEN-1:0]  in_pc;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_ins;
  logic [XLEN-1:0]  out_pc;
  logic [XLEN-1:0]  out_pc8;
  logic [4:0]       out_rs;
  logic [4:0]       out_rt;
  logic [4:0]       out_rd;
  logic [15:0]      out_imm16;
  logic [25:0]      out_imm26;
  logic             jump_d;
  logic             out_delay_slot;
  logic             flush;
  logic             flush_keep_pc;
  logic [XLEN-1:0]  npc;
  logic [CNT_W-1:0] count;

  modport slave (
    input  in_valid, in_ins, in_pc, out_ready, jump_d, flush, flush_keep_pc, npc,
    output in_ready, out_valid, out_ins, out_pc, out_pc8, out_rs, out_rt, out_rd,
           out_imm16, out_imm26, out_delay_slot, count
  );

  modport master (
    output in_valid, in_ins, in_pc, out_ready, jump_d, flush, flush_keep_pc, npc,
    input  in_ready, out_valid, out_ins, out_pc, out_pc8, out_rs, out_rt, out_rd,
           out_imm16, out_imm26, out_delay_slot, count
  );
endinterface

// File: rtl/fd_queue.sv
// DEPTH-entry fetch/decode instruction FIFO with flush bubble, PC+8 and delay-slot marking.
// Optional macro FD_QUEUE_BYPASS_EN: empty queue forwards the fetch word to decode in the same cycle.
module fd_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic     clock,
  input  logic     reset,
  fd_queue_if.slave q
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [XLEN-1:0]  ins_mem [DEPTH];
  logic [XLEN-1:0]  pc_mem  [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] cnt;
  logic             slot_pending;
  logic [XLEN-1:0]  bubble_pc;

  logic full, empty, bypass, bypass_take, push, pop, store, retire;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign full  = (cnt == CNT_FULL);
  assign empty = (cnt == '0);

`ifdef FD_QUEUE_BYPASS_EN
  assign bypass = empty & q.in_valid;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed word that decode takes right away never touches storage.
  assign bypass_take = bypass & q.out_ready;

  assign q.in_ready  = ~full | q.out_ready;
  assign q.out_valid = ~empty | bypass;
  assign push        = q.in_valid & q.in_ready & ~q.flush;
  assign pop         = q.out_valid & q.out_ready & ~q.flush;
  assign store       = push & ~bypass_take;
  assign retire      = pop & ~bypass_take;

  always_comb begin
    q.out_ins = '0;
    q.out_pc  = bubble_pc;
    if (!empty) begin
      q.out_ins = ins_mem[rd_ptr];
      q.out_pc  = pc_mem[rd_ptr];
    end else if (bypass) begin
      q.out_ins = q.in_ins;
      q.out_pc  = q.in_pc;
    end
  end

  assign q.out_pc8        = q.out_pc + XLEN'(8);
  assign q.out_rs         = q.out_ins[25:21];
  assign q.out_rt         = q.out_ins[20:16];
  assign q.out_rd         = q.out_ins[15:11];
  assign q.out_imm16      = q.out_ins[15:0];
  assign q.out_imm26      = q.out_ins[25:0];
  assign q.out_delay_slot = slot_pending & q.out_valid;
  assign q.count          = cnt;

  // Control state: reset beats flush, flush beats push/pop.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      cnt          <= '0;
      slot_pending <= 1'b0;
      bubble_pc    <= '0;
    end else if (q.flush) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      cnt          <= '0;
      slot_pending <= 1'b0;
      bubble_pc    <= q.flush_keep_pc ? q.npc : '0;
    end else begin
      if (store)  wr_ptr <= ptr_next(wr_ptr);
      if (retire) rd_ptr <= ptr_next(rd_ptr);
      case ({store, retire})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (pop) slot_pending <= q.jump_d;
    end
  end

  // Entry storage is data only; stale entries are masked by the occupancy count.
  always_ff @(posedge clock) begin
    if (store) begin
      ins_mem[wr_ptr] <= q.in_ins;
      pc_mem[wr_ptr]  <= q.in_pc;
    end
  end
endmodule

// File: tb/tb_fd_queue.sv
// Scoreboard bench for fd_queue: stimulus queues expected heads, a negedge monitor checks each consumed word.
module tb_fd_queue;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
    bit          chk_ds;
    bit          ds;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  fd_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  fd_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clock (clock),
    .reset (reset),
    .q     (bus.slave)
  );

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic neg();
    @(negedge clock);
  endtask

  task automatic offer(input logic [31:0] ins, input logic [31:0] pc);
    bus.in_valid = 1'b1;
    bus.in_ins   = ins;
    bus.in_pc    = pc;
  endtask

  task automatic expect_word(input logic [31:0] ins, input logic [31:0] pc,
                             input bit chk_ds, input bit ds);
    exp_t e;
    e.ins = ins; e.pc = pc; e.chk_ds = chk_ds; e.ds = ds;
    sb.push_back(e);
  endtask

  // Monitor: every word decode consumes must be the oldest outstanding expectation.
  always @(negedge clock) begin
    if (!reset && bus.out_valid && bus.out_ready && !bus.flush) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_pop: got ins %0h pc %0h expected no word", bus.out_ins, bus.out_pc);
      end else begin
        mon_e = sb.pop_front();
        check("pop_ins",   bus.out_ins,   mon_e.ins);
        check("pop_pc",    bus.out_pc,    mon_e.pc);
        check("pop_pc8",   bus.out_pc8,   mon_e.pc + 32'd8);
        check("pop_rs",    bus.out_rs,    mon_e.ins[25:21]);
        check("pop_imm16", bus.out_imm16, mon_e.ins[15:0]);
        if (mon_e.chk_ds) check("pop_delay_slot", bus.out_delay_slot, mon_e.ds);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_ins = '0; bus.in_pc = '0;
    bus.out_ready = 1'b0; bus.jump_d = 1'b0;
    bus.flush = 1'b0; bus.flush_keep_pc = 1'b0; bus.npc = '0;
    cyc(); cyc();
    reset = 1'b0;
    neg();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_ins",   bus.out_ins, 0);
    check("rst_out_pc",    bus.out_pc, 0);
    check("rst_out_pc8",   bus.out_pc8, 32'd8);
    check("rst_count",     bus.count, 0);
    check("rst_in_ready",  bus.in_ready, 1);
    check("rst_delay",     bus.out_delay_slot, 0);

    // Fill to full with decode stalled; fifth word refused.
    for (int i = 0; i < 4; i++) begin
      cyc();
      offer(32'h24010001 + i, 32'h3000 + 4 * i);
      expect_word(32'h24010001 + i, 32'h3000 + 4 * i, 1'b0, 1'b0);
    end
    cyc();
    offer(32'h24010005, 32'h3010);
    neg();
    check("full_count",    bus.count, 4);
    check("full_in_ready", bus.in_ready, 0);
    cyc();
    bus.in_valid = 1'b0;
    neg();
    check("refused_count", bus.count, 4);
    cyc();
    bus.out_ready = 1'b1;
    repeat (3) cyc();
    cyc();
    bus.out_ready = 1'b0;
    neg();
    check("drain_count", bus.count, 0);
    check("drain_valid", bus.out_valid, 0);

    // Full-rate streaming at full occupancy with pointer wrap.
    k = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      offer(32'h24020000 + k, 32'h5000 + 4 * k);
      expect_word(32'h24020000 + k, 32'h5000 + 4 * k, 1'b0, 1'b0);
      k++;
    end
    for (int j = 0; j < 10; j++) begin
      cyc();
      offer(32'h24020000 + k, 32'h5000 + 4 * k);
      expect_word(32'h24020000 + k, 32'h5000 + 4 * k, 1'b0, 1'b0);
      bus.out_ready = 1'b1;
      k++;
      neg();
      check("stream_count",    bus.count, 4);
      check("stream_in_ready", bus.in_ready, 1);
    end
    cyc();
    bus.in_valid = 1'b0;
    repeat (3) cyc();
    cyc();
    bus.out_ready = 1'b0;
    neg();
    check("stream_drain_count", bus.count, 0);

    // Delay-slot marking, including persistence across an empty gap.
    cyc(); offer(32'h10000003, 32'h6000); expect_word(32'h10000003, 32'h6000, 1'b1, 1'b0);
    cyc(); offer(32'h24030001, 32'h6004); expect_word(32'h24030001, 32'h6004, 1'b1, 1'b1);
    cyc(); offer(32'h24030002, 32'h6008); expect_word(32'h24030002, 32'h6008, 1'b1, 1'b0);
    cyc(); bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.jump_d = 1'b1;
    cyc(); bus.jump_d = 1'b0;
    cyc(); bus.jump_d = 1'b1;
    cyc(); bus.out_ready = 1'b0; bus.jump_d = 1'b0;
    neg();
    check("gap_valid", bus.out_valid, 0);
    check("gap_delay", bus.out_delay_slot, 0);
    cyc(); offer(32'h24030003, 32'h600C); expect_word(32'h24030003, 32'h600C, 1'b1, 1'b1);
    cyc(); bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.jump_d = 1'b0;
    cyc(); bus.out_ready = 1'b0;

    // Flush with keep-pc while holding three entries and a pending delay slot.
    for (int i = 0; i < 4; i++) begin
      cyc();
      offer(32'h24040001 + i, 32'h7000 + 4 * i);
      if (i == 0) expect_word(32'h24040001, 32'h7000, 1'b1, 1'b0);
    end
    cyc(); bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.jump_d = 1'b1;
    cyc(); bus.out_ready = 1'b0; bus.jump_d = 1'b0;
    neg();
    check("preflush_count", bus.count, 3);
    check("preflush_delay", bus.out_delay_slot, 1);
    cyc();
    bus.flush = 1'b1; bus.flush_keep_pc = 1'b1; bus.npc = 32'h4180;
    offer(32'h24049999, 32'h7010);
    cyc();
    bus.flush = 1'b0; bus.flush_keep_pc = 1'b0; bus.npc = 32'h0; bus.in_valid = 1'b0;
    neg();
    check("flush_count", bus.count, 0);
    check("flush_valid", bus.out_valid, 0);
    check("flush_ins",   bus.out_ins, 0);
    check("flush_pc",    bus.out_pc, 32'h4180);
    check("flush_pc8",   bus.out_pc8, 32'h4188);
    cyc(); offer(32'h24050001, 32'h8000); expect_word(32'h24050001, 32'h8000, 1'b1, 1'b0);
    cyc(); bus.in_valid = 1'b0;
    neg();
    check("postflush_valid", bus.out_valid, 1);
    check("postflush_delay", bus.out_delay_slot, 0);
    cyc(); bus.out_ready = 1'b1;
    cyc(); bus.out_ready = 1'b0;
    neg();
    check("bubble_hold_pc",    bus.out_pc, 32'h4180);
    check("bubble_hold_count", bus.count, 0);
    cyc(); bus.flush = 1'b1; bus.npc = 32'h1234;
    cyc(); bus.flush = 1'b0; bus.npc = 32'h0;
    neg();
    check("plain_flush_pc",  bus.out_pc, 0);
    check("plain_flush_pc8", bus.out_pc8, 32'd8);

    // Empty queue with fetch and decode both ready.
    cyc();
    offer(32'h24060001, 32'h9000);
    bus.out_ready = 1'b1;
    expect_word(32'h24060001, 32'h9000, 1'b0, 1'b0);
`ifdef FD_QUEUE_BYPASS_EN
    neg();
    check("bypass_same_cycle_valid", bus.out_valid, 1);
    check("bypass_count", bus.count, 0);
    cyc();
    bus.in_valid = 1'b0;
    neg();
    check("bypass_after_count", bus.count, 0);
`else
    neg();
    check("nobypass_same_cycle_valid", bus.out_valid, 0);
    cyc();
    bus.in_valid = 1'b0;
    neg();
    check("nobypass_next_valid", bus.out_valid, 1);
    cyc();
    neg();
    check("nobypass_after_count", bus.count, 0);
`endif
    cyc();
    bus.out_ready = 1'b0;

    // Every expected word must have been consumed within a bounded window.
    for (int w = 0; w < 20 && sb.size() != 0; w++) cyc();
    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d outstanding expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
